match_ctrl: RTL
===============

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 CLK_FREQ, 27_000_000, clk frequency in Hz, sets 1 s tick period.
REQ-002 WIN_ROUNDS, 2, round wins needed to take the match (best-of-3).
REQ-003 COUNT_S, 3, countdown seconds per round.
REQ-004 SHOW_S, 2, seconds a round result is held.
REQ-005 clk  input  1  system clock; all logic on posedge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rx_data  input  8  UART command byte.
REQ-008 rx_data_valid  input  1  byte-valid level; command taken on its rising edge.
REQ-009 hand  output  4  [1:0] left, [3:2] right; 0 scissors, 1 rock, 2 paper, 3 none.
REQ-010 countdown  output  4  seconds remaining in COUNT, else 0.
REQ-011 show  output  1  high in SHOW and OVER.
REQ-012 result  output  2  last round: 00 draw, 10 left win, 11 right win.
REQ-013 left_wins  output  4  rounds won by left this match.
REQ-014 right_wins  output  4  rounds won by right this match.
REQ-015 round_no  output  4  current round, 1-based; 0 when idle.
REQ-016 match_over  output  1  high in OVER.
REQ-017 winner  output  2  00 none, 10 left, 11 right.

Function
REQ-018 Command SHALL be accepted only in a cycle where rx_data_valid=1 and its previous-cycle sample=0; one command per rising edge, rx_data sampled that cycle.
REQ-019 Bytes: 0x30-0x32 left hand 0-2, 0x33-0x35 right hand 0-2, 0x38 start, 0x37 abort; all others ignored.
REQ-020 FSM states IDLE, COUNT, JUDGE, SHOW, OVER.
REQ-021 IDLE: 0x38 -> COUNT; round_no=1, countdown=COUNT_S, hand=4'hF.
REQ-022 COUNT: hand bytes overwrite own field (last wins); hand bytes in any other state ignored.
REQ-023 COUNT: each 1 s tick decrements countdown; tick with countdown==1 -> JUDGE, countdown=0.
REQ-024 Hand byte coincident with final tick SHALL be latched and used in judgment.
REQ-025 JUDGE lasts one cycle: left wins for (L,R) in {(1,0),(2,1),(0,2)}, right wins mirrored, equal is draw; winner's counter +1; -> SHOW.
REQ-026 SHOW held SHOW_S ticks; then either counter == WIN_ROUNDS -> OVER, winner set; else -> COUNT, round_no+1 (saturate 15), hand=4'hF, countdown=COUNT_S.
REQ-027 Win counters SHALL never exceed WIN_ROUNDS.
REQ-028 OVER: outputs frozen; 0x38 clears counters and winner, round_no=1 -> COUNT.
REQ-029 0x37 in any state -> IDLE next cycle with all outputs at reset values; abort beats a coincident tick.
REQ-030 Seconds counter runs 0..CLK_FREQ-1 and is cleared on every state entry so each second is full length.

Reset
REQ-031 rst SHALL force state IDLE, hand 4'hF, countdown 0, show 0, result 00, both counters 0, round_no 0, match_over 0, winner 00, seconds counter 0.
REQ-032 Edge-detect register SHALL reset to 1 so valid held high across reset release is not a command; reset mid-round discards the round.

Configuration
REQ-033 MATCH_FORFEIT_EN defined: side with hand 3 at JUDGE loses the round; both missing is a draw.
REQ-034 MATCH_FORFEIT_EN undefined: any missing hand gives result 00, counters unchanged, round_no not incremented (round replayed after SHOW).

Structure
REQ-035 Package match_pkg SHALL hold the state enum, hand codes, result codes, command byte constants and the judge function.
REQ-036 Sub-module sec_tick (parameter CLK_FREQ, input clr, one-cycle tick output) SHALL generate the 1 s tick.

Verification (CLK_FREQ=10)
REQ-037 0x38, 0x31, 0x33 -> countdown 3,2,1,0; result 10, left_wins 1, show high 20 cycles, round_no 2.
REQ-038 Left wins two rounds -> match_over 1, winner 10; later 0x30 leaves hand unchanged; 0x38 restarts with round_no 1.
REQ-039 Only 0x32 sent: with MATCH_FORFEIT_EN result 10, left_wins 1; without it result 00, round_no stays 1.
REQ-040 0x37 at countdown 2 -> next cycle all reset values, state IDLE.
REQ-041 rx_data_valid high 5 cycles with 0x31 -> one command; 0x34 on final-tick cycle is judged.
REQ-042 0x31 and 0x34 -> result 00, counters unchanged, round_no increments.

Source files
------------

// File: rtl/match_pkg.sv
// match_pkg: shared types and constants for the rock-paper-scissors match controller.
// Holds the FSM state enum, hand/result/winner codes, UART command bytes and the round judge.
package match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_JUDGE,
    ST_SHOW,
    ST_OVER
  } state_t;

  localparam logic [1:0] HAND_SCISSORS = 2'd0;
  localparam logic [1:0] HAND_ROCK     = 2'd1;
  localparam logic [1:0] HAND_PAPER    = 2'd2;
  localparam logic [1:0] HAND_NONE     = 2'd3;

  localparam logic [1:0] RES_DRAW  = 2'b00;
  localparam logic [1:0] RES_LEFT  = 2'b10;
  localparam logic [1:0] RES_RIGHT = 2'b11;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b11;

  localparam logic [7:0] CMD_LEFT_LO  = 8'h30;
  localparam logic [7:0] CMD_LEFT_HI  = 8'h32;
  localparam logic [7:0] CMD_RIGHT_LO = 8'h33;
  localparam logic [7:0] CMD_RIGHT_HI = 8'h35;
  localparam logic [7:0] CMD_ABORT    = 8'h37;
  localparam logic [7:0] CMD_START    = 8'h38;

  // Judge two real hands: rock beats scissors, paper beats rock, scissors beats paper.
  function automatic logic [1:0] judge(input logic [1:0] l, input logic [1:0] r);
    logic [1:0] res;
    if (l == r) begin
      res = RES_DRAW;
    end else if ((l == HAND_ROCK     && r == HAND_SCISSORS) ||
                 (l == HAND_PAPER    && r == HAND_ROCK)     ||
                 (l == HAND_SCISSORS && r == HAND_PAPER)) begin
      res = RES_LEFT;
    end else begin
      res = RES_RIGHT;
    end
    return res;
  endfunction

endpackage

// File: rtl/match_if.sv
// match_if: UART command input and scoreboard outputs of the match controller.
// The master side drives commands and observes the score; the slave side is the controller.
interface match_if;

  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic [3:0] hand;
  logic [3:0] countdown;
  logic       show;
  logic [1:0] result;
  logic [3:0] left_wins;
  logic [3:0] right_wins;
  logic [3:0] round_no;
  logic       match_over;
  logic [1:0] winner;

  modport master (
    output rx_data, rx_data_valid,
    input  hand, countdown, show, result, left_wins, right_wins,
           round_no, match_over, winner
  );

  modport slave (
    input  rx_data, rx_data_valid,
    output hand, countdown, show, result, left_wins, right_wins,
           round_no, match_over, winner
  );

endinterface

// File: rtl/sec_tick.sv
// sec_tick: one-cycle pulse every CLK_FREQ cycles; clr restarts the second from zero
// so that whoever clears it gets a full-length first second.
module sec_tick #(
  parameter int CLK_FREQ = 27_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_o
);

  localparam int              CW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLK_FREQ - 1);

  logic [CW-1:0] secCnt_q;

  // Count cycles within the current second, wrapping at the last cycle or on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      secCnt_q <= '0;
    end else if (clr || secCnt_q == LAST) begin
      secCnt_q <= '0;
    end else begin
      secCnt_q <= secCnt_q + 1'b1;
    end
  end

  assign tick_o = (secCnt_q == LAST);

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: best-of-N rock-paper-scissors match controller driven by UART command bytes.
// Build macro MATCH_FORFEIT_EN: when defined, a side showing no hand at judgment loses the
// round; when undefined, any missing hand voids the round and it is replayed.
module match_ctrl
  import match_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int WIN_ROUNDS = 2,
  parameter int COUNT_S    = 3,
  parameter int SHOW_S     = 2
) (
  input logic   clk,
  input logic   rst,
  match_if.slave bus_if
);

  localparam logic [3:0] WIN_CNT    = 4'(WIN_ROUNDS);
  localparam logic [3:0] CNT_START  = 4'(COUNT_S);
  localparam logic [3:0] SHOW_START = 4'(SHOW_S);

  state_t     state_q, state_d;
  logic       validPrev_q;
  logic [3:0] hand_q, hand_d;
  logic [3:0] countdown_q, countdown_d;
  logic [3:0] showCnt_q, showCnt_d;
  logic [3:0] leftWins_q, leftWins_d;
  logic [3:0] rightWins_q, rightWins_d;
  logic [3:0] roundNo_q, roundNo_d;
  logic [1:0] result_q, result_d;
  logic [1:0] winner_q, winner_d;
  logic       replay_q, replay_d;

  logic       tick, secClr;
  logic       cmdValid, isStart, isAbort, isLeft, isRight;
  logic [1:0] leftCode, rightCode, lHand, rHand, roundRes;

  sec_tick #(.CLK_FREQ(CLK_FREQ)) uSecTick (
    .clk    (clk),
    .rst    (rst),
    .clr    (secClr),
    .tick_o (tick)
  );

  assign secClr    = (state_d != state_q);
  assign cmdValid  = bus_if.rx_data_valid & ~validPrev_q;
  assign isStart   = cmdValid && (bus_if.rx_data == CMD_START);
  assign isAbort   = cmdValid && (bus_if.rx_data == CMD_ABORT);
  assign isLeft    = cmdValid && (bus_if.rx_data >= CMD_LEFT_LO)  && (bus_if.rx_data <= CMD_LEFT_HI);
  assign isRight   = cmdValid && (bus_if.rx_data >= CMD_RIGHT_LO) && (bus_if.rx_data <= CMD_RIGHT_HI);
  assign leftCode  = bus_if.rx_data[1:0];
  assign rightCode = bus_if.rx_data[1:0] + 2'd1;
  assign lHand     = hand_q[1:0];
  assign rHand     = hand_q[3:2];

  // State and scoreboard registers; the edge detector powers up high so a held valid is not a command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      validPrev_q <= 1'b1;
      hand_q      <= 4'hF;
      countdown_q <= 4'd0;
      showCnt_q   <= 4'd0;
      leftWins_q  <= 4'd0;
      rightWins_q <= 4'd0;
      roundNo_q   <= 4'd0;
      result_q    <= RES_DRAW;
      winner_q    <= WIN_NONE;
      replay_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      validPrev_q <= bus_if.rx_data_valid;
      hand_q      <= hand_d;
      countdown_q <= countdown_d;
      showCnt_q   <= showCnt_d;
      leftWins_q  <= leftWins_d;
      rightWins_q <= rightWins_d;
      roundNo_q   <= roundNo_d;
      result_q    <= result_d;
      winner_q    <= winner_d;
      replay_q    <= replay_d;
    end
  end

  // Next-state logic: match sequencing, hand capture, judging; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    hand_d      = hand_q;
    countdown_d = countdown_q;
    showCnt_d   = showCnt_q;
    leftWins_d  = leftWins_q;
    rightWins_d = rightWins_q;
    roundNo_d   = roundNo_q;
    result_d    = result_q;
    winner_d    = winner_q;
    replay_d    = replay_q;
    roundRes    = RES_DRAW;

    case (state_q)
      ST_IDLE: begin
        if (isStart) begin
          state_d     = ST_COUNT;
          roundNo_d   = 4'd1;
          countdown_d = CNT_START;
          hand_d      = 4'hF;
        end
      end
      ST_COUNT: begin
        if (isLeft)  hand_d[1:0] = leftCode;
        if (isRight) hand_d[3:2] = rightCode;
        if (tick) begin
          if (countdown_q <= 4'd1) begin
            countdown_d = 4'd0;
            state_d     = ST_JUDGE;
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end
      end
      ST_JUDGE: begin
        state_d   = ST_SHOW;
        showCnt_d = SHOW_START;
        replay_d  = 1'b0;
`ifdef MATCH_FORFEIT_EN
        if (lHand == HAND_NONE && rHand == HAND_NONE) roundRes = RES_DRAW;
        else if (lHand == HAND_NONE)                  roundRes = RES_RIGHT;
        else if (rHand == HAND_NONE)                  roundRes = RES_LEFT;
        else                                          roundRes = judge(lHand, rHand);
`else
        if (lHand == HAND_NONE || rHand == HAND_NONE) begin
          roundRes = RES_DRAW;
          replay_d = 1'b1;
        end else begin
          roundRes = judge(lHand, rHand);
        end
`endif
        result_d = roundRes;
        if (roundRes == RES_LEFT && leftWins_q < WIN_CNT)   leftWins_d  = leftWins_q + 4'd1;
        if (roundRes == RES_RIGHT && rightWins_q < WIN_CNT) rightWins_d = rightWins_q + 4'd1;
      end
      ST_SHOW: begin
        if (tick) begin
          if (showCnt_q <= 4'd1) begin
            showCnt_d = 4'd0;
            if (leftWins_q == WIN_CNT) begin
              state_d  = ST_OVER;
              winner_d = WIN_LEFT;
            end else if (rightWins_q == WIN_CNT) begin
              state_d  = ST_OVER;
              winner_d = WIN_RIGHT;
            end else begin
              state_d     = ST_COUNT;
              hand_d      = 4'hF;
              countdown_d = CNT_START;
              if (!replay_q && roundNo_q != 4'd15) roundNo_d = roundNo_q + 4'd1;
            end
          end else begin
            showCnt_d = showCnt_q - 4'd1;
          end
        end
      end
      ST_OVER: begin
        if (isStart) begin
          state_d     = ST_COUNT;
          leftWins_d  = 4'd0;
          rightWins_d = 4'd0;
          winner_d    = WIN_NONE;
          roundNo_d   = 4'd1;
          hand_d      = 4'hF;
          countdown_d = CNT_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (isAbort) begin
      state_d     = ST_IDLE;
      hand_d      = 4'hF;
      countdown_d = 4'd0;
      showCnt_d   = 4'd0;
      leftWins_d  = 4'd0;
      rightWins_d = 4'd0;
      roundNo_d   = 4'd0;
      result_d    = RES_DRAW;
      winner_d    = WIN_NONE;
      replay_d    = 1'b0;
    end
  end

  assign bus_if.hand       = hand_q;
  assign bus_if.countdown  = countdown_q;
  assign bus_if.show       = (state_q == ST_SHOW) || (state_q == ST_OVER);
  assign bus_if.result     = result_q;
  assign bus_if.left_wins  = leftWins_q;
  assign bus_if.right_wins = rightWins_q;
  assign bus_if.round_no   = roundNo_q;
  assign bus_if.match_over = (state_q == ST_OVER);
  assign bus_if.winner     = winner_q;

endmodule
